mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port, fixed-latency unified memory between two requesters of the pipelined RV32 core: instruction fetch (read-only) and the memory stage (load/store). It runs one transaction at a time through a small FSM and arbitrates with data-first priority plus a fetch starvation guard. It returns per-port stall signals that the hazard logic ORs into its fetch-stage and memory-stage stalls.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports.
DATA_WIDTH, 32, data word width.
MEM_LATENCY, 2, cycles from the mem_en_o cycle to the cycle mem_rdata_i is valid. Must be at least 1.
STARVE_LIMIT, 4, consecutive contested arbitrations fetch may lose before it is forced to win. Must be at least 1.

Ports:
clk_i  in  1  clock. All state changes on the rising edge.
rst_ni  in  1  asynchronous, active-low reset.
f_req_i  in  1  fetch read request. Held with f_addr_i until f_ack_o.
f_addr_i  in  ADDR_WIDTH  fetch address.
f_ack_o  out  1  one-cycle pulse: fetch transaction complete.
f_rdata_o  out  DATA_WIDTH  fetch read data. Valid with f_ack_o, held until the next fetch ack.
stall_f_o  out  1  f_req_i & ~f_ack_o.
d_req_i  in  1  data request. Held with its fields until d_ack_o.
d_we_i  in  1  1 = store, 0 = load.
d_addr_i  in  ADDR_WIDTH  data address.
d_wdata_i  in  DATA_WIDTH  store data.
d_ack_o  out  1  one-cycle pulse: data transaction complete.
d_rdata_o  out  DATA_WIDTH  load data. Valid with d_ack_o, held until the next data ack.
stall_d_o  out  1  d_req_i & ~d_ack_o.
mem_en_o  out  1  memory access strobe, exactly one cycle per transaction.
mem_we_o  out  1  memory write enable. Qualified by mem_en_o.
mem_addr_o  out  ADDR_WIDTH  memory address. Registered.
mem_wdata_o  out  DATA_WIDTH  memory write data. Registered.
mem_rdata_i  in  DATA_WIDTH  memory read data. Valid MEM_LATENCY cycles after mem_en_o.

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - All outputs go to 0, including rdata holding registers, latched fields and the starve counter.
  - Any in-flight read is discarded; no ack is ever issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If no request is pending, stay in IDLE.
  - If any request is pending, pick a winner and latch the winner id, we, addr and wdata. Go to ISSUE.
- ISSUE (one cycle)
  - mem_en_o = 1; mem_we_o, mem_addr_o and mem_wdata_o come from the latched fields.
  - Write: go to RESP.
  - Read: load the latency counter with MEM_LATENCY and go to WAIT.
- WAIT
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, capture mem_rdata_i into the winner's rdata register and go to RESP.
- RESP (one cycle)
  - Pulse the winner's ack. The other port's ack stays 0.
  - Go to IDLE. Requests seen in RESP are ignored.
- Timing, request first seen in IDLE at cycle 0:
  - mem_en_o in cycle 1.
  - Read ack in cycle MEM_LATENCY+2.
  - Write ack in cycle 2.
  - Next arbitration no earlier than the cycle after the ack.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both requesting: data wins, unless the starve counter equals STARVE_LIMIT, in which case fetch wins.
  - Starve counter: +1 on each contested arbitration that fetch loses; cleared whenever fetch wins; saturates at STARVE_LIMIT.
- Request withdrawal:
  - Before grant: permitted, no effect.
  - After grant (e.g. fetch flushed by a taken branch): the transaction still completes and the ack still pulses. The requester ignores it. No second mem_en_o is issued for the same grant.
- The data port is never starved: at most one fetch is forced between data grants.
- Exactly one transaction is in flight at any time; mem_en_o is never high in two consecutive cycles.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - port_id_t enum {PORT_FETCH, PORT_DATA}.
  - Latency counter width constant: $clog2(MEM_LATENCY+1).
- Sub-module mem_arb_prio: combinational winner select plus the registered starve counter. Inputs: both requests and an arbitrate strobe. Outputs: winner id and a grant-valid flag.

Test Plan:
- Reset mid-read (rst_ni low during WAIT) -> all outputs 0 immediately. After release: IDLE, no ack for the aborted read.
- Fetch read, MEM_LATENCY=2, f_addr=0x10, memory returns 0xDEADBEEF -> mem_en_o=1, mem_addr_o=0x10 in cycle 1. f_ack_o in cycle 4 with f_rdata_o=0xDEADBEEF. stall_f_o high in cycles 0-3.
- Store, d_addr=0x40, d_wdata=0x12345678 -> cycle 1: mem_en_o=1, mem_we_o=1, mem_wdata_o=0x12345678. d_ack_o in cycle 2. f_ack_o stays 0.
- f_req and d_req both raised in cycle 0 (loads) -> data mem_en_o in cycle 1, d_ack_o in cycle 4. Fetch mem_en_o in cycle 6, f_ack_o in cycle 9.
- Both held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F. Starve counter returns to 0 after each fetch grant.
- f_req dropped the cycle after its grant -> exactly one mem_en_o, f_ack_o still pulses, then IDLE with no further fetch access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
//   arb_state_t : transaction FSM states (IDLE, ISSUE, WAIT, RESP)
//   port_id_t   : which requester owns the current transaction
//   lat_cnt_w() : width of the read-latency down-counter for a given latency
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      PORT_FETCH = 1'b0,
      PORT_DATA  = 1'b1
   } port_id_t;

   localparam int MEM_LATENCY_DEFAULT = 2;

   // The counter is loaded with the latency itself, so it needs to hold
   // values 0..lat inclusive.
   function automatic int lat_cnt_w(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

   localparam int LAT_CNT_W = lat_cnt_w(MEM_LATENCY_DEFAULT);

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select for the memory port arbiter.
// Data wins a contested arbitration unless fetch has already lost
// STARVE_LIMIT contested arbitrations in a row, in which case fetch is forced.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   f_req_i       : fetch request
//   d_req_i       : data request
//   arb_i         : arbitration strobe (FSM is idle and may grant)
//   win_o         : winning port (meaningful when gnt_o is high)
//   gnt_o         : a grant is made this cycle
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     f_req_i,
   input  logic     d_req_i,
   input  logic     arb_i,
   output port_id_t win_o,
   output logic     gnt_o
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_q, starve_d;
   logic          forced;

   always_comb begin
      forced   = (starve_q == SW'(STARVE_LIMIT));
      gnt_o    = arb_i & (f_req_i | d_req_i);
      win_o    = (f_req_i & (~d_req_i | forced)) ? PORT_FETCH : PORT_DATA;
      starve_d = starve_q;
      if (gnt_o) begin
         if (win_o == PORT_FETCH) begin
            starve_d = '0;
         end else if (f_req_i && !forced) begin
            // Fetch was also asking and lost: count it, saturating.
            starve_d = starve_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch
// (read-only) and the memory stage (load/store). One transaction at a time:
// IDLE -> ISSUE -> [WAIT ->] RESP -> IDLE.
// Ports:
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   f_req_i, f_addr_i              : fetch request / address (held until ack)
//   f_ack_o, f_rdata_o, stall_f_o  : fetch ack pulse, read data, stall
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i                      : data request fields (held until ack)
//   d_ack_o, d_rdata_o, stall_d_o  : data ack pulse, load data, stall
//   mem_en_o, mem_we_o, mem_addr_o,
//   mem_wdata_o                    : registered memory command
//   mem_rdata_i                    : memory read data, MEM_LATENCY after en
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  f_req_i,
   input  logic [ADDR_WIDTH-1:0] f_addr_i,
   output logic                  f_ack_o,
   output logic [DATA_WIDTH-1:0] f_rdata_o,
   output logic                  stall_f_o,
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [ADDR_WIDTH-1:0] d_addr_i,
   input  logic [DATA_WIDTH-1:0] d_wdata_i,
   output logic                  d_ack_o,
   output logic [DATA_WIDTH-1:0] d_rdata_o,
   output logic                  stall_d_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam int CNT_W = lat_cnt_w(MEM_LATENCY);

   arb_state_t            state_q, state_d;
   port_id_t              winner_q, winner_d;
   logic                  en_q, en_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  f_ack_q, f_ack_d;
   logic                  d_ack_q, d_ack_d;
   logic [DATA_WIDTH-1:0] f_rdata_q, f_rdata_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

   port_id_t              win;
   logic                  gnt;

   mem_arb_prio #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_prio (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .f_req_i(f_req_i),
      .d_req_i(d_req_i),
      .arb_i  (state_q == IDLE),
      .win_o  (win),
      .gnt_o  (gnt)
   );

   always_comb begin
      state_d   = state_q;
      winner_d  = winner_q;
      en_d      = 1'b0;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      f_ack_d   = 1'b0;
      d_ack_d   = 1'b0;
      f_rdata_d = f_rdata_q;
      d_rdata_d = d_rdata_q;

      case (state_q)
         IDLE: begin
            if (gnt) begin
               // Latch the command now so ISSUE drives mem_* straight from flops.
               winner_d = win;
               en_d     = 1'b1;
               if (win == PORT_FETCH) begin
                  we_d    = 1'b0;
                  addr_d  = f_addr_i;
                  wdata_d = '0;
               end else begin
                  we_d    = d_we_i;
                  addr_d  = d_addr_i;
                  wdata_d = d_wdata_i;
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               // Acks are registered, so raise them on entry to RESP.
               f_ack_d = (winner_q == PORT_FETCH);
               d_ack_d = (winner_q == PORT_DATA);
               state_d = RESP;
            end else begin
               cnt_d   = CNT_W'(MEM_LATENCY);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               if (winner_q == PORT_FETCH) begin
                  f_rdata_d = mem_rdata_i;
                  f_ack_d   = 1'b1;
               end else begin
                  d_rdata_d = mem_rdata_i;
                  d_ack_d   = 1'b1;
               end
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         winner_q  <= PORT_FETCH;
         en_q      <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         f_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         f_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         winner_q  <= winner_d;
         en_q      <= en_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         f_ack_q   <= f_ack_d;
         d_ack_q   <= d_ack_d;
         f_rdata_q <= f_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign mem_en_o    = en_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign f_ack_o     = f_ack_q;
   assign d_ack_o     = d_ack_q;
   assign f_rdata_o   = f_rdata_q;
   assign d_rdata_o   = d_rdata_q;
   assign stall_f_o   = f_req_i & ~f_ack_q;
   assign stall_d_o   = d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4).
// Cycle 0 of each scenario is the first cycle the DUT sees the request in IDLE.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_ack;
   logic [31:0] f_rdata;
   logic        stall_f;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        stall_d;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .MEM_LATENCY (2),
      .STARVE_LIMIT(4)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .f_req_i    (f_req),
      .f_addr_i   (f_addr),
      .f_ack_o    (f_ack),
      .f_rdata_o  (f_rdata),
      .stall_f_o  (stall_f),
      .d_req_i    (d_req),
      .d_we_i     (d_we),
      .d_addr_i   (d_addr),
      .d_wdata_i  (d_wdata),
      .d_ack_o    (d_ack),
      .d_rdata_o  (d_rdata),
      .stall_d_o  (stall_d),
      .mem_en_o   (mem_en),
      .mem_we_o   (mem_we),
      .mem_addr_o (mem_addr),
      .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: 0x10 holds 0xDEADBEEF, everything else {~addr[15:0], addr[15:0]}.
   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return {~a[15:0], a[15:0]};
   endfunction

   // Two-stage read pipe: data is valid exactly 2 cycles after the mem_en cycle,
   // and zero otherwise so an early/late capture is visible.
   logic        p1_v;
   logic [31:0] p1_d;
   always @(posedge clk) begin
      p1_v      <= mem_en & ~mem_we;
      p1_d      <= mem_model(mem_addr);
      mem_rdata <= p1_v ? p1_d : 32'h0;
   end

   task automatic test_reset;
      f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      rst_n = 0;
      #12;
      checks++;
      if ({mem_en, mem_we, f_ack, d_ack, stall_f, stall_d} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl: got en/we/fack/dack/sf/sd=%b want 000000",
                            {mem_en, mem_we, f_ack, d_ack, stall_f, stall_d});
      end
      checks++;
      if ({mem_addr, mem_wdata, f_rdata, d_rdata} !== 128'b0) begin
         errors++; $display("FAIL reset_data: addr=%h wdata=%h frd=%h drd=%h want all 0",
                            mem_addr, mem_wdata, f_rdata, d_rdata);
      end
      #3 rst_n = 1;
      @(posedge clk); #1;
      $display("test_reset done");
   endtask

   task automatic test_fetch_read;
      f_addr = 32'h10; f_req = 1;
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         checks++;
         if (mem_en !== (c == 1)) begin
            errors++; $display("FAIL fetch_en c%0d: got %b want %b", c, mem_en, (c == 1));
         end
         checks++;
         if (f_ack !== (c == 4)) begin
            errors++; $display("FAIL fetch_ack c%0d: got %b want %b", c, f_ack, (c == 4));
         end
         checks++;
         if (stall_f !== (c <= 3)) begin
            errors++; $display("FAIL fetch_stall c%0d: got %b want %b", c, stall_f, (c <= 3));
         end
         checks++;
         if (d_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_dack c%0d: got %b want 0", c, d_ack);
         end
         if (c == 1) begin
            checks++;
            if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
               errors++; $display("FAIL fetch_cmd: addr=%h we=%b want 00000010 0", mem_addr, mem_we);
            end
         end
         if (c == 4) begin
            checks++;
            if (f_rdata !== 32'hDEADBEEF) begin
               errors++; $display("FAIL fetch_rdata: got %h want deadbeef", f_rdata);
            end
         end
         @(posedge clk); #1;
         if (c == 4) f_req = 0;
      end
      $display("test_fetch_read done");
   endtask

   task automatic test_store;
      d_addr = 32'h40; d_wdata = 32'h12345678; d_we = 1; d_req = 1;
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         checks++;
         if (mem_en !== (c == 1)) begin
            errors++; $display("FAIL store_en c%0d: got %b want %b", c, mem_en, (c == 1));
         end
         checks++;
         if (d_ack !== (c == 2) || f_ack !== 1'b0) begin
            errors++; $display("FAIL store_ack c%0d: got d=%b f=%b want d=%b f=0", c, d_ack, f_ack, (c == 2));
         end
         checks++;
         if (stall_d !== (c <= 1)) begin
            errors++; $display("FAIL store_stall c%0d: got %b want %b", c, stall_d, (c <= 1));
         end
         if (c == 1) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678) begin
               errors++; $display("FAIL store_cmd: we=%b addr=%h wdata=%h want 1 00000040 12345678",
                                  mem_we, mem_addr, mem_wdata);
            end
         end
         @(posedge clk); #1;
         if (c == 2) begin d_req = 0; d_we = 0; end
      end
      $display("test_store done");
   endtask

   task automatic test_contended;
      f_addr = 32'h24; f_req = 1;
      d_addr = 32'h80; d_we = 0; d_req = 1;
      for (int c = 0; c <= 11; c++) begin
         @(negedge clk);
         checks++;
         if (mem_en !== (c == 1 || c == 6)) begin
            errors++; $display("FAIL cont_en c%0d: got %b want %b", c, mem_en, (c == 1 || c == 6));
         end
         checks++;
         if (d_ack !== (c == 4) || f_ack !== (c == 9)) begin
            errors++; $display("FAIL cont_ack c%0d: got d=%b f=%b want d=%b f=%b",
                               c, d_ack, f_ack, (c == 4), (c == 9));
         end
         if (c == 1) begin
            checks++;
            if (mem_addr !== 32'h80) begin
               errors++; $display("FAIL cont_addr_d: got %h want 00000080", mem_addr);
            end
         end
         if (c == 6) begin
            checks++;
            if (mem_addr !== 32'h24) begin
               errors++; $display("FAIL cont_addr_f: got %h want 00000024", mem_addr);
            end
         end
         if (c == 4) begin
            checks++;
            if (d_rdata !== 32'hFF7F0080) begin
               errors++; $display("FAIL cont_drdata: got %h want ff7f0080", d_rdata);
            end
         end
         if (c == 9) begin
            checks++;
            if (f_rdata !== 32'hFFDB0024) begin
               errors++; $display("FAIL cont_frdata: got %h want ffdb0024", f_rdata);
            end
         end
         @(posedge clk); #1;
         if (c == 4) d_req = 0;
         if (c == 9) f_req = 0;
      end
      $display("test_contended done");
   endtask

   task automatic test_starvation;
      logic [9:0] order;
      order  = 10'b1000010000;   // bit k set: grant k goes to fetch (D,D,D,D,F,D,D,D,D,F)
      f_addr = 32'h100; d_addr = 32'h200; d_we = 0;
      f_req  = 1; d_req = 1;
      for (int c = 0; c <= 49; c++) begin
         @(negedge clk);
         checks++;
         if (mem_en !== ((c % 5) == 1)) begin
            errors++; $display("FAIL starve_en c%0d: got %b want %b", c, mem_en, ((c % 5) == 1));
         end
         if ((c % 5) == 1) begin
            checks++;
            if (mem_addr !== (order[c / 5] ? 32'h100 : 32'h200)) begin
               errors++; $display("FAIL starve_grant%0d: got addr %h want %h", c / 5, mem_addr,
                                  (order[c / 5] ? 32'h100 : 32'h200));
            end
         end
         checks++;
         if (f_ack !== ((c % 5) == 4 && order[c / 5]) || d_ack !== ((c % 5) == 4 && !order[c / 5])) begin
            errors++; $display("FAIL starve_ack c%0d: got f=%b d=%b want f=%b d=%b", c, f_ack, d_ack,
                               ((c % 5) == 4 && order[c / 5]), ((c % 5) == 4 && !order[c / 5]));
         end
         if (c == 24 || c == 49) begin
            checks++;
            if (f_rdata !== 32'hFEFF0100) begin
               errors++; $display("FAIL starve_frdata c%0d: got %h want feff0100", c, f_rdata);
            end
         end
         if (c == 19) begin
            checks++;
            if (d_rdata !== 32'hFDFF0200) begin
               errors++; $display("FAIL starve_drdata: got %h want fdff0200", d_rdata);
            end
         end
         @(posedge clk); #1;
      end
      f_req = 0; d_req = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (mem_en !== 1'b0) begin
            errors++; $display("FAIL starve_idle c%0d: got en=%b want 0", c, mem_en);
         end
         @(posedge clk); #1;
      end
      $display("test_starvation done");
   endtask

   task automatic test_withdraw;
      f_addr = 32'h30; f_req = 1;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         checks++;
         if (mem_en !== (c == 1)) begin
            errors++; $display("FAIL wd_en c%0d: got %b want %b", c, mem_en, (c == 1));
         end
         checks++;
         if (f_ack !== (c == 4)) begin
            errors++; $display("FAIL wd_ack c%0d: got %b want %b", c, f_ack, (c == 4));
         end
         if (c == 4) begin
            checks++;
            if (f_rdata !== 32'hFFCF0030) begin
               errors++; $display("FAIL wd_rdata: got %h want ffcf0030", f_rdata);
            end
         end
         @(posedge clk); #1;
         if (c == 0) f_req = 0;
      end
      $display("test_withdraw done");
   endtask

   task automatic test_reset_mid_read;
      f_addr = 32'h44; f_req = 1;
      for (int c = 0; c <= 2; c++) begin
         @(negedge clk);
         if (c == 1) begin
            checks++;
            if (mem_en !== 1'b1 || mem_addr !== 32'h44) begin
               errors++; $display("FAIL mid_issue: en=%b addr=%h want 1 00000044", mem_en, mem_addr);
            end
         end
         if (c < 2) begin
            @(posedge clk); #1;
         end
      end
      // In WAIT now; assert reset between edges and check outputs clear at once.
      #2 rst_n = 0; f_req = 0;
      #1;
      checks++;
      if ({mem_en, mem_we, f_ack, d_ack} !== 4'b0) begin
         errors++; $display("FAIL mid_rst_ctrl: got en/we/fack/dack=%b want 0000",
                            {mem_en, mem_we, f_ack, d_ack});
      end
      checks++;
      if ({mem_addr, mem_wdata, f_rdata, d_rdata} !== 128'b0) begin
         errors++; $display("FAIL mid_rst_data: addr=%h wdata=%h frd=%h drd=%h want all 0",
                            mem_addr, mem_wdata, f_rdata, d_rdata);
      end
      @(negedge clk); #2 rst_n = 1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (f_ack !== 1'b0 || d_ack !== 1'b0 || mem_en !== 1'b0) begin
            errors++; $display("FAIL mid_after c%0d: got fack=%b dack=%b en=%b want 0 0 0",
                               c, f_ack, d_ack, mem_en);
         end
      end
      $display("test_reset_mid_read done");
   endtask

   initial begin
      test_reset();
      test_fetch_read();
      test_store();
      test_contended();
      test_starvation();
      test_withdraw();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time bound so the bench always ends.
   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded 20000 time units");
      $fatal(1, "timeout");
   end

endmodule
